// File: rtl/ascon_result_tx.sv
// Serializes the ASCON cipher wave and tag into the UART transmitter using the Load/TxBusy handshake.
// Optional build macro ASCON_TX_CHECKSUM_EN appends an XOR checksum byte after the tag.
module ascon_result_tx #(
    parameter int CIPHER_BYTES = 184,
    parameter int TAG_BYTES    = 16,
    parameter int NDBits       = 8
) (
    input  logic                             clock_i,
    input  logic                             resetb_i,
    input  logic                             Start_i,
    input  logic [CIPHER_BYTES*NDBits-1:0]   Cipher_i,
    input  logic [TAG_BYTES*NDBits-1:0]      Tag_i,
    input  logic                             TxBusy_i,
    output logic [NDBits-1:0]                TxByte_o,
    output logic                             Load_o,
    output logic                             Busy_o,
    output logic                             Done_o
);

    localparam int DATA_BYTES = CIPHER_BYTES + TAG_BYTES;
`ifdef ASCON_TX_CHECKSUM_EN
    localparam int TOTAL_BYTES = DATA_BYTES + 1;
`else
    localparam int TOTAL_BYTES = DATA_BYTES;
`endif
    localparam int IDX_W = $clog2(TOTAL_BYTES + 2);
    localparam int SR_W  = DATA_BYTES * NDBits;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_FREE,
        DONE
    } state_t;

    state_t              state_q;
    logic [SR_W-1:0]     shiftReg_q;
    logic [IDX_W-1:0]    byteIdx_q;
    logic [IDX_W-1:0]    byteIdx_d;
    logic [NDBits-1:0]   txByte_q;
    logic [NDBits-1:0]   nextByte_d;
    logic                load_q;
    logic                busy_q;
    logic                done_q;
`ifdef ASCON_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(DATA_BYTES);
    logic [NDBits-1:0]   csum_q;
`endif

    always_comb begin
        byteIdx_d  = byteIdx_q + IDX_W'(1);
        nextByte_d = shiftReg_q[SR_W-1 -: NDBits];
`ifdef ASCON_TX_CHECKSUM_EN
        if (byteIdx_q == CSUM_IDX) begin
            nextByte_d = csum_q;
        end
`endif
    end

    // The byte on the wire is always the top of the snapshot; it shifts left once the UART frees up.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            byteIdx_q  <= '0;
            txByte_q   <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef ASCON_TX_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start_i) begin
                        shiftReg_q <= {Cipher_i, Tag_i};
                        byteIdx_q  <= '0;
                        busy_q     <= 1'b1;
`ifdef ASCON_TX_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (!TxBusy_i) begin
                        txByte_q <= nextByte_d;
                        load_q   <= 1'b1;
`ifdef ASCON_TX_CHECKSUM_EN
                        csum_q   <= csum_q ^ shiftReg_q[SR_W-1 -: NDBits];
`endif
                        state_q  <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (TxBusy_i) begin
                        state_q <= WAIT_FREE;
                    end
                end
                WAIT_FREE: begin
                    if (!TxBusy_i) begin
                        shiftReg_q <= shiftReg_q << NDBits;
                        byteIdx_q  <= byteIdx_d;
                        if (byteIdx_d == LAST_IDX) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TxByte_o = txByte_q;
    assign Load_o   = load_q;
    assign Busy_o   = busy_q;
    assign Done_o   = done_q;

endmodule

// File: doc/ascon_result_tx.md
Name: ascon_result_tx

Overview:
- Transmit-side serializer for the ASCON link. It is the counterpart of the byte deserializer that assembles key, nonce, AD and wave from UART RX.
- Snapshots the encrypted wave and the 128-bit tag when ASCON signals completion. Streams them byte-by-byte into the UART core transmitter using the Load/TxBusy handshake.
- Sits between the ASCON engine outputs and the UART core Din/LD inputs.

Parameters:
- CIPHER_BYTES, 184, number of cipher bytes (1472 bits).
- TAG_BYTES, 16, number of tag bytes (128 bits).
- NDBits, 8, UART data width in bits.

Ports:
- clock_i  in  1  main clock
- resetb_i  in  1  asynchronous reset, active low
- Start_i  in  1  single-cycle pulse: cipher and tag are valid
- Cipher_i  in  CIPHER_BYTES*NDBits  cipher wave
- Tag_i  in  TAG_BYTES*NDBits  authentication tag
- TxBusy_i  in  1  UART transmitter busy
- TxByte_o  out  NDBits  byte presented to the UART (Din)
- Load_o  out  1  single-cycle load strobe to the UART (LD)
- Busy_o  out  1  high from Start acceptance until Done
- Done_o  out  1  single-cycle pulse after the last byte has left the UART

Behaviour:
Clock and reset:
- Single clock, clock_i. Reset is resetb_i, asynchronous, active low.
- Reset values: TxByte_o=0, Load_o=0, Busy_o=0, Done_o=0, state=IDLE, byte index=0, snapshot register=0.

Snapshot and byte order:
- On Start_i=1 in IDLE, Cipher_i and Tag_i are copied into an internal (CIPHER_BYTES+TAG_BYTES)*NDBits shift register.
- Later changes on Cipher_i and Tag_i do not affect the transfer.
- Transmission order: cipher most-significant byte first (Cipher_i[1471:1464] first, Cipher_i[7:0] last), then tag most-significant byte first (Tag_i[127:120] ... Tag_i[7:0]).
- Total = CIPHER_BYTES+TAG_BYTES = 200 bytes.
- Index counter width: $clog2(total+2). It counts bytes sent and never wraps.

States:
- IDLE: Busy_o=0. On Start_i, capture the snapshot, set index=0, set Busy_o=1, go to LOAD.
- LOAD: if TxBusy_i=0, drive TxByte_o = current top byte, assert Load_o for exactly one cycle, go to WAIT_BUSY. If TxBusy_i=1, stay in LOAD with Load_o=0.
- WAIT_BUSY: hold TxByte_o. Wait for TxBusy_i=1, then go to WAIT_FREE.
- WAIT_FREE: wait for TxBusy_i=0. Then shift the register left by NDBits and increment index. If index now equals total, go to DONE; otherwise go to LOAD.
- DONE: Done_o=1 for one cycle, Busy_o=0 in the same cycle. Next cycle: IDLE.

Timing and handshake:
- Load_o is never asserted while TxBusy_i=1.
- Load_o is never asserted twice for the same byte.
- Minimum latency: Start_i to the first Load_o = 2 cycles (capture, then LOAD).
- TxByte_o is stable from the Load_o cycle until the WAIT_FREE exit.

Boundary conditions:
- Start_i outside IDLE, including the DONE cycle: ignored, with no re-snapshot.
- Start_i in the cycle after DONE (state IDLE): accepted normally.
- TxBusy_i already high when LOAD is entered: wait in LOAD, no strobe.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0. The partial transfer is abandoned and no Done_o is issued.

Optional Feature:
- Macro: ASCON_TX_CHECKSUM_EN.
- Defined: a running XOR of every transmitted byte is kept, cleared at Start acceptance. After the last tag byte, one extra byte equal to that XOR is sent through the same LOAD/WAIT_BUSY/WAIT_FREE handshake. Total = 201 bytes, and Done_o follows the checksum byte.
- Undefined: no checksum logic, total = 200 bytes.

Test Plan:
- Cipher_i byte k = k[7:0] (MSB byte 0x00 ... LSB byte 0xB7), Tag_i = 0x00112233445566778899AABBCCDDEEFF. UART model holds TxBusy_i high for 10 cycles after each Load_o. Required: 200 Load_o pulses with bytes 0x00..0xB7, then 0x00,0x11,...,0xFF, then a single Done_o.
- Cipher_i/Tag_i changed to all-0xA5 one cycle after Start_i. Required: the transmitted stream still matches the original snapshot.
- TxBusy_i held high for 50 cycles at Start_i. Required: no Load_o until TxBusy_i falls; the first byte is then loaded exactly once.
- Second Start_i pulse at byte index 37. Required: ignored; byte count stays 200; single Done_o.
- resetb_i pulsed low at byte index 100. Required: outputs 0 immediately, no Done_o. A new Start_i then sends the full 200 bytes from byte 0.
- With ASCON_TX_CHECKSUM_EN, data from the first test. Required: 201st byte = XOR of all 200 bytes; Done_o follows it. Without the macro: exactly 200 bytes.
